// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 active-low matrix keypad model driven by a
// valid/ready press-command port. Each press closes the addressed contact
// for HOLD_CYC cycles, then leaves it open for GAP_CYC cycles before the
// next command is accepted.
// Optional contact bounce: define KEYPAD_EMU_BOUNCE_EN to insert
// LFSR-driven bounce windows of BOUNCE_CYC cycles around the hold phase.
module keypad_emulator #(
    parameter int HOLD_CYC   = 120000,
    parameter int GAP_CYC    = 120000,
    parameter int BOUNCE_CYC = 600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_valid_i,
    input  logic [3:0] key_i,
    output logic       key_ready_o,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       pressed_o,
    output logic       busy_o
);

    // Zero durations behave as one cycle.
    localparam int HOLD_E = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int GAP_E  = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int MAX_A  = (HOLD_E > GAP_E) ? HOLD_E : GAP_E;
    localparam int MAX_C  = (MAX_A > BOUNCE_CYC) ? MAX_A : BOUNCE_CYC;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_E - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_E - 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CW-1:0] BNC_LD = CW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_ON,
        S_HOLD,
        S_BOUNCE_OFF,
        S_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [3:0]      key_q;
    logic [1:0]      kr;
    logic [1:0]      kc;
    logic            contact;
    logic            accept;

    assign accept = key_valid_i && (state == S_IDLE);

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [7:0] lfsr;

    // Free-running bounce pattern, x^8+x^6+x^5+x^4+1, seeded on reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`endif

    // State, shared down-counter and latched key code
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            key_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                key_q <= key_i;
            end
        end
    end

    // Next state; the counter is reloaded with (duration - 1) on every entry
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    if (BOUNCE_CYC > 0) begin
                        state_nxt = S_BOUNCE_ON;
                        cnt_nxt   = BNC_LD;
                    end else begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = HOLD_LD;
                    end
`else
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_ON: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_BOUNCE_OFF: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`endif
            S_HOLD: begin
                if (cnt == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    if (BOUNCE_CYC > 0) begin
                        state_nxt = S_BOUNCE_OFF;
                        cnt_nxt   = BNC_LD;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LD;
                    end
`else
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LD;
`endif
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Handshake and contact state from the current FSM state
    always_comb begin
        key_ready_o = (state == S_IDLE);
        busy_o      = ~key_ready_o;
        contact     = 1'b0;
        case (state)
            S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_ON:  contact = (cnt == '0) ? 1'b1 : lfsr[0];
            S_BOUNCE_OFF: contact = (cnt == '0) ? 1'b0 : lfsr[0];
`endif
            default:      contact = 1'b0;
        endcase
        pressed_o = contact;
    end

    // Key code to (row, column) position on the matrix
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (key_q)
            4'h1: begin kr = 2'd0; kc = 2'd0; end
            4'h2: begin kr = 2'd0; kc = 2'd1; end
            4'h3: begin kr = 2'd0; kc = 2'd2; end
            4'hA: begin kr = 2'd0; kc = 2'd3; end
            4'h4: begin kr = 2'd1; kc = 2'd0; end
            4'h5: begin kr = 2'd1; kc = 2'd1; end
            4'h6: begin kr = 2'd1; kc = 2'd2; end
            4'hB: begin kr = 2'd1; kc = 2'd3; end
            4'h7: begin kr = 2'd2; kc = 2'd0; end
            4'h8: begin kr = 2'd2; kc = 2'd1; end
            4'h9: begin kr = 2'd2; kc = 2'd2; end
            4'hC: begin kr = 2'd2; kc = 2'd3; end
            4'hE: begin kr = 2'd3; kc = 2'd0; end
            4'h0: begin kr = 2'd3; kc = 2'd1; end
            4'hF: begin kr = 2'd3; kc = 2'd2; end
            default: begin kr = 2'd3; kc = 2'd3; end
        endcase
    end

    // Switch path: a closed contact on a driven-low row pulls its column low
    always_comb begin
        col_o = '1;
        if (contact && !row_i[kr]) begin
            col_o[kc] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed/randomized bench for keypad_emulator in the
// default (no bounce) build, checked against a press-timeline model.
module tb_keypad_emulator;

    localparam int H = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       key_valid_i;
    logic [3:0] key_i;
    logic       key_ready_o;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic       pressed_o;
    logic       busy_o;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYC  (H),
        .GAP_CYC   (G),
        .BOUNCE_CYC(6)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_valid_i(key_valid_i),
        .key_i      (key_i),
        .key_ready_o(key_ready_o),
        .row_i      (row_i),
        .col_o      (col_o),
        .pressed_o  (pressed_o),
        .busy_o     (busy_o)
    );

    int ncomp = 0;
    int nfail = 0;

    // Reference model: t = cycles since the accepting edge (0 = idle)
    int t = 0;
    int mkey = 0;
    int model_accepts = 0;
    int dut_presses = 0;
    logic prev_pressed = 1'b0;
    int rowof[16];
    int colof[16];
    int layout[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    function automatic logic [3:0] exp_col(int k, logic [3:0] row, bit pr);
        logic [3:0] c;
        c = 4'b1111;
        if (pr && row[rowof[k]] == 1'b0) c[colof[k]] = 1'b0;
        return c;
    endfunction

    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit pr;
        pr = (t >= 1 && t <= H);
        check({tag, "/ready"},   {3'b000, key_ready_o}, {3'b000, t == 0});
        check({tag, "/busy"},    {3'b000, busy_o},      {3'b000, t != 0});
        check({tag, "/pressed"}, {3'b000, pressed_o},   {3'b000, pr});
        check({tag, "/col"},     col_o,                 exp_col(mkey, row_i, pr));
    endtask

    // One clock: model advances with the inputs sampled at the edge
    task automatic tick();
        @(posedge clk);
        if (!rstn) begin
            t = 0;
            mkey = 0;
        end else if (t == 0) begin
            if (key_valid_i) begin
                t = 1;
                mkey = int'(key_i);
                model_accepts++;
            end
        end else if (t < H + G) begin
            t++;
        end else begin
            t = 0;
        end
        #1;
        if (pressed_o && !prev_pressed) dut_presses++;
        prev_pressed = pressed_o;
    endtask

    task automatic press(logic [3:0] k, string tag);
        key_valid_i = 1'b1;
        key_i = k;
        tick();
        check_all(tag);
        key_valid_i = 1'b0;
        key_i = 4'($urandom);
    endtask

    // Runs until the model is idle, bounded; DUT checked every cycle
    task automatic run_to_idle(string tag, bit rand_row);
        int n;
        n = 0;
        while (t != 0 && n < 50) begin
            if (rand_row) row_i = 4'($urandom);
            key_i = 4'($urandom);
            tick();
            check_all(tag);
            n++;
        end
        check({tag, "/idle"}, {3'b000, key_ready_o}, 4'b0001);
    endtask

    initial begin
        logic [3:0] rot[4];
        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rowof[layout[r][c]] = r;
                colof[layout[r][c]] = c;
            end

        rstn = 1'b0;
        key_valid_i = 1'b0;
        key_i = 4'h0;
        row_i = 4'b0000;
        tick();
        tick();
        check_all("reset");
        check("reset/col", col_o, 4'b1111);
        rstn = 1'b1;
        tick();
        check_all("post_reset");

        // Press A on row 0
        row_i = 4'b1110;
        press(4'hA, "keyA");
        check("keyA/col_first", col_o, 4'b0111);
        run_to_idle("keyA", 1'b0);

        // Reset in the middle of HOLD
        row_i = 4'b0000;
        press(4'h7, "rst_mid");
        for (int i = 0; i < 3; i++) begin tick(); check_all("rst_mid_hold"); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_all("rst_mid_after");
        check("rst_mid/col", col_o, 4'b1111);
        press(4'h9, "after_rst");
        run_to_idle("after_rst", 1'b0);

        // Press 5 while rotating rows; col_o follows row_i with no latency
        press(4'h5, "key5");
        for (int i = 0; i < H + G + 2; i++) begin
            row_i = rot[i % 4];
            #1;
            check_all("key5_rot");
            tick();
            check_all("key5_tick");
        end

        // valid held high with changing key codes: one press per accept
        model_accepts = 0;
        dut_presses = 0;
        row_i = 4'b0000;
        key_valid_i = 1'b1;
        for (int i = 0; i < 25; i++) begin
            key_i = 4'($urandom);
            tick();
            check_all("held_valid");
        end
        key_valid_i = 1'b0;
        run_to_idle("held_valid", 1'b0);
        check("held/presses", 4'(dut_presses), 4'(model_accepts));

        // Full key-map sweep with all rows low
        row_i = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            press(4'(k), "sweep");
            run_to_idle("sweep", 1'b0);
        end

        // Random keys and random row patterns
        for (int i = 0; i < 8; i++) begin
            row_i = 4'($urandom);
            press(4'($urandom), "rand");
            run_to_idle("rand", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
